// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: default sizing and FSM state type.
package restoring_divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/restoring_divider_sub_stage.sv
// Combinational N-bit subtractor A - B built as a ripple of full-adder cells
// fed with inverted B and carry-in 1; Borrow is the inverted carry-out.
module sub_stage #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Diff,
  output logic         Borrow
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    Diff     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      Diff[i]    = A[i] ^ ~B[i] ^ carry[i];
      carry[i+1] = (A[i] & ~B[i]) | (carry[i] & (A[i] ^ ~B[i]));
    end
    Borrow = ~carry[N];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// Start/Busy/Done handshake, divide-by-zero short-circuits straight to FIN.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d, r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   r_shift, trial;
  logic             borrow;
  logic [WIDTH-1:0] q_next, r_next;

  // The restored remainder is always below D, so only WIDTH bits are stored;
  // the extra bit exists only in the shifted value fed to the subtractor.
  always_comb r_shift = {r_q, q_q[WIDTH-1]};

  sub_stage #(.N(WIDTH + 1)) u_sub (
    .A      (r_shift),
    .B      ({1'b0, d_q}),
    .Diff   (trial),
    .Borrow (borrow)
  );

  always_comb begin
    q_next = {q_q[WIDTH-2:0], ~borrow};
    r_next = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = '0;
    Busy    = 1'b0;
    Done    = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        Done    = (state_q == FIN);
        state_d = IDLE;
        if (Start) begin
          d_d = Divisor;
          if (Divisor != '0) begin
            q_d     = Dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = Dividend;
            quot_d  = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        Busy = 1'b1;
        q_d  = q_next;
        r_d  = r_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = q_next;
          rem_d   = r_next;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      d_q    <= d_d;
      r_q    <= r_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      cnt_q  <= cnt_d;
    end
  end

  // With R < D on entry to each step, the difference MSB equals the borrow.
  always_ff @(posedge Clk) begin
    if (Rst_n && state_q == RUN) assert (trial[WIDTH] == borrow);
  end

  always_comb begin
    Quotient  = quot_q;
    Remainder = rem_q;
    DivByZero = dbz_q;
  end

endmodule
